rat_intr_flag_ctrl: RTL and testbench

//  Interrupt sequencer for the RAT MCU. Sits between the control unit and the C/Z flag register block.
//  - Latches edge-triggered interrupt sources and resolves them by fixed priority.
//  - Handshakes one interrupt at a time with the control unit.
//  - Drives flag save on entry: shadow load.
//  - Drives flag restore on RETIE/RETID: load-select plus C/Z load.
//  - Owns the I (interrupt enable) flag.

---
 rtl/rat_intr_pkg.sv | 28 ++
 rtl/rat_intr_flag_ctrl_irq_edge_pend.sv | 34 +++
 rtl/rat_intr_flag_ctrl.sv | 137 +++++++++++++
 tb/tb_rat_intr_flag_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rat_intr_pkg.sv
// Shared types and helpers for the RAT interrupt sequencer.
package rat_intr_pkg;

    // Widest source vector the priority encoder accepts
    localparam int MAX_SRC   = 32;
    localparam int MAX_IDX_W = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        SAVE    = 3'd2,
        ISR     = 3'd3,
        RESTORE = 3'd4
    } intr_state_t;

    // Lowest set index wins; returns 0 when nothing is set
    function automatic logic [MAX_IDX_W-1:0] prio_enc(input logic [MAX_SRC-1:0] vec);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rat_intr_flag_ctrl_irq_edge_pend.sv
// Rising-edge detector and pending latch for the interrupt sources.
module irq_edge_pend #(
    parameter int N_SRC = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_SRC-1:0] irq_i,
    input  logic [N_SRC-1:0] clr_i,
    output logic [N_SRC-1:0] pend_o
);

    logic [N_SRC-1:0] irqPrevQ;
    logic [N_SRC-1:0] pendQ;
    logic [N_SRC-1:0] pendD;

    // A fresh edge in the clear cycle keeps the bit set
    always_comb begin
        pendD = (pendQ & ~clr_i) | (irq_i & ~irqPrevQ);
    end

    // Previous-sample and pending registers; a source high at reset release counts as an edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irqPrevQ <= '0;
            pendQ    <= '0;
        end else begin
            irqPrevQ <= irq_i;
            pendQ    <= pendD;
        end
    end

    assign pend_o = pendQ;

endmodule

// File: rtl/rat_intr_flag_ctrl.sv
// Interrupt sequencer: priority resolution, control-unit handshake, flag save/restore, I flag.
module rat_intr_flag_ctrl
    import rat_intr_pkg::*;
#(
    parameter int N_SRC = 8,
    parameter int VEC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_SRC-1:0] irq_i,
    input  logic [N_SRC-1:0] irq_mask_i,
    input  logic             i_set_i,
    input  logic             i_clr_i,
    input  logic             int_ack_i,
    input  logic             reti_exec_i,
    input  logic             reti_ie_i,
    output logic             int_req_o,
    output logic [VEC_W-1:0] int_vec_o,
    output logic             flg_shad_ld_o,
    output logic             flg_ld_sel_o,
    output logic             flg_rst_ld_o,
    output logic             i_flag_o,
    output logic             in_isr_o,
    output logic             stray_reti_o
);

    intr_state_t          stateQ, stateD;
    logic                 intReqQ, intReqD;
    logic [VEC_W-1:0]     intVecQ, intVecD;
    logic                 iFlagQ, iFlagD;
    logic                 retiIeQ, retiIeD;
    logic                 strayQ, strayD;
    logic [N_SRC-1:0]     pend;
    logic [N_SRC-1:0]     clrVec;
    logic [N_SRC-1:0]     reqVec;
    logic                 req;
    logic [MAX_IDX_W-1:0] prioIdx;

    irq_edge_pend #(
        .N_SRC (N_SRC)
    ) uEdgePend (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .irq_i  (irq_i),
        .clr_i  (clrVec),
        .pend_o (pend)
    );

    assign reqVec  = pend & irq_mask_i;
    assign req     = |reqVec;
    assign prioIdx = prio_enc(MAX_SRC'(reqVec));

    // Next-state logic: handshake, I flag ownership and the RETI qualifier capture
    always_comb begin
        stateD  = stateQ;
        intReqD = intReqQ;
        intVecD = intVecQ;
        iFlagD  = iFlagQ;
        retiIeD = retiIeQ;
        strayD  = 1'b0;
        clrVec  = '0;
        if (i_clr_i) begin
            iFlagD = 1'b0;
        end else if (i_set_i) begin
            iFlagD = 1'b1;
        end
        unique case (stateQ)
            IDLE: begin
                if (iFlagQ && req) begin
                    stateD  = REQ;
                    intReqD = 1'b1;
                end
                strayD = reti_exec_i;
            end
            REQ: begin
                if (int_ack_i) begin
                    stateD  = SAVE;
                    intVecD = VEC_W'(prioIdx);
                    clrVec  = req ? (N_SRC'(1) << prioIdx) : '0;
                    iFlagD  = 1'b0;
                    intReqD = 1'b0;
                end else if (i_clr_i || !req) begin
                    stateD  = IDLE;
                    intReqD = 1'b0;
                end
                strayD = reti_exec_i;
            end
            SAVE: begin
                stateD = ISR;
                strayD = reti_exec_i;
            end
            ISR: begin
                if (reti_exec_i) begin
                    stateD  = RESTORE;
                    retiIeD = reti_ie_i;
                end
            end
            RESTORE: begin
                stateD = IDLE;
                iFlagD = retiIeQ;
            end
            default: begin
                stateD  = IDLE;
                intReqD = 1'b0;
            end
        endcase
    end

    // State and registered outputs, all cleared immediately on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stateQ  <= IDLE;
            intReqQ <= 1'b0;
            intVecQ <= '0;
            iFlagQ  <= 1'b0;
            retiIeQ <= 1'b0;
            strayQ  <= 1'b0;
        end else begin
            stateQ  <= stateD;
            intReqQ <= intReqD;
            intVecQ <= intVecD;
            iFlagQ  <= iFlagD;
            retiIeQ <= retiIeD;
            strayQ  <= strayD;
        end
    end

    assign int_req_o     = intReqQ;
    assign int_vec_o     = intVecQ;
    assign i_flag_o      = iFlagQ;
    assign stray_reti_o  = strayQ;
    assign flg_shad_ld_o = (stateQ == SAVE);
    assign flg_ld_sel_o  = (stateQ == RESTORE);
    assign flg_rst_ld_o  = (stateQ == RESTORE);
    assign in_isr_o      = (stateQ == SAVE) || (stateQ == ISR) || (stateQ == RESTORE);

endmodule

// File: tb/tb_rat_intr_flag_ctrl.sv
// Directed bench for the RAT interrupt sequencer.
module tb_rat_intr_flag_ctrl;

    logic       clk;
    logic       rstN;
    logic [7:0] irq;
    logic [7:0] irqMask;
    logic       iSet;
    logic       iClr;
    logic       intAck;
    logic       retiExec;
    logic       retiIe;
    logic       intReq;
    logic [2:0] intVec;
    logic       flgShadLd;
    logic       flgLdSel;
    logic       flgRstLd;
    logic       iFlag;
    logic       inIsr;
    logic       strayReti;

    int checks;
    int failures;

    typedef struct {
        logic [7:0] irqPat;
        logic [7:0] mask;
        logic       expReq;
        logic [2:0] expVec;
    } vec_t;

    vec_t vecTab[8];

    rat_intr_flag_ctrl #(
        .N_SRC (8),
        .VEC_W (3)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .irq_i         (irq),
        .irq_mask_i    (irqMask),
        .i_set_i       (iSet),
        .i_clr_i       (iClr),
        .int_ack_i     (intAck),
        .reti_exec_i   (retiExec),
        .reti_ie_i     (retiIe),
        .int_req_o     (intReq),
        .int_vec_o     (intVec),
        .flg_shad_ld_o (flgShadLd),
        .flg_ld_sel_o  (flgLdSel),
        .flg_rst_ld_o  (flgRstLd),
        .i_flag_o      (iFlag),
        .in_isr_o      (inIsr),
        .stray_reti_o  (strayReti)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison against a bench-computed value
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive all inputs idle
    task automatic applyStimulus(input logic [7:0] irqV, input logic [7:0] maskV);
        irq      = irqV;
        irqMask  = maskV;
        iSet     = 1'b0;
        iClr     = 1'b0;
        intAck   = 1'b0;
        retiExec = 1'b0;
        retiIe   = 1'b0;
    endtask

    // Reset pulse followed by reset-value checks
    task automatic doReset();
        applyStimulus(8'h00, 8'hFF);
        rstN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        checkOutput("rst_int_req", {31'b0, intReq}, 32'd0);
        checkOutput("rst_int_vec", {29'b0, intVec}, 32'd0);
        checkOutput("rst_i_flag", {31'b0, iFlag}, 32'd0);
        checkOutput("rst_in_isr", {31'b0, inIsr}, 32'd0);
    endtask

    // Single-cycle SEI
    task automatic doSei();
        iSet = 1'b1;
        step();
        iSet = 1'b0;
    endtask

    // Single-cycle ack, leaves DUT in SAVE
    task automatic doAck();
        intAck = 1'b1;
        step();
        intAck = 1'b0;
    endtask

    // Single-cycle RETIE/RETID, leaves DUT in RESTORE
    task automatic doReti(input logic ie);
        retiExec = 1'b1;
        retiIe   = ie;
        step();
        retiExec = 1'b0;
        retiIe   = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rstN     = 1'b1;
        applyStimulus(8'h00, 8'hFF);

        vecTab[0] = '{irqPat: 8'h08, mask: 8'hFF, expReq: 1'b1, expVec: 3'd3};
        vecTab[1] = '{irqPat: 8'h22, mask: 8'hFF, expReq: 1'b1, expVec: 3'd1};
        vecTab[2] = '{irqPat: 8'h04, mask: 8'hFB, expReq: 1'b0, expVec: 3'd0};
        vecTab[3] = '{irqPat: 8'h81, mask: 8'hFE, expReq: 1'b1, expVec: 3'd7};
        vecTab[4] = '{irqPat: 8'hF0, mask: 8'hFF, expReq: 1'b1, expVec: 3'd4};
        vecTab[5] = '{irqPat: 8'h01, mask: 8'hFF, expReq: 1'b1, expVec: 3'd0};
        vecTab[6] = '{irqPat: 8'h00, mask: 8'hFF, expReq: 1'b0, expVec: 3'd0};
        vecTab[7] = '{irqPat: 8'h40, mask: 8'h40, expReq: 1'b1, expVec: 3'd6};

        // Table: SEI, edge, request after two edges, ack and save pulse
        for (int i = 0; i < 8; i++) begin
            doReset();
            doSei();
            checkOutput("tab_i_flag_set", {31'b0, iFlag}, 32'd1);
            applyStimulus(vecTab[i].irqPat, vecTab[i].mask);
            step();
            checkOutput("tab_req_early", {31'b0, intReq}, 32'd0);
            step();
            checkOutput("tab_req", {31'b0, intReq}, {31'b0, vecTab[i].expReq});
            if (vecTab[i].expReq) begin
                doAck();
                checkOutput("tab_vec", {29'b0, intVec}, {29'b0, vecTab[i].expVec});
                checkOutput("tab_shad_ld", {31'b0, flgShadLd}, 32'd1);
                checkOutput("tab_i_flag_clr", {31'b0, iFlag}, 32'd0);
                checkOutput("tab_req_drop", {31'b0, intReq}, 32'd0);
                step();
                checkOutput("tab_shad_ld_end", {31'b0, flgShadLd}, 32'd0);
                checkOutput("tab_in_isr", {31'b0, inIsr}, 32'd1);
            end
        end

        // Two sources, RETID then RETIE; no nesting and restore override
        doReset();
        doSei();
        irq = 8'h22;
        step();
        step();
        checkOutput("s2_req", {31'b0, intReq}, 32'd1);
        doAck();
        checkOutput("s2_vec1", {29'b0, intVec}, 32'd1);
        step();
        iSet = 1'b1;
        step();
        iSet = 1'b0;
        step();
        checkOutput("s2_no_nest", {31'b0, intReq}, 32'd0);
        checkOutput("s2_isr_sei", {31'b0, iFlag}, 32'd1);
        iClr = 1'b1;
        step();
        iClr = 1'b0;
        doReti(1'b0);
        checkOutput("s2_ld_sel", {31'b0, flgLdSel}, 32'd1);
        checkOutput("s2_rst_ld", {31'b0, flgRstLd}, 32'd1);
        checkOutput("s2_restore_isr", {31'b0, inIsr}, 32'd1);
        iSet = 1'b1;
        step();
        iSet = 1'b0;
        checkOutput("s2_ld_sel_end", {31'b0, flgLdSel}, 32'd0);
        checkOutput("s2_retid_iflag", {31'b0, iFlag}, 32'd0);
        checkOutput("s2_idle_isr", {31'b0, inIsr}, 32'd0);
        step();
        step();
        checkOutput("s2_retid_noreq", {31'b0, intReq}, 32'd0);
        doSei();
        step();
        checkOutput("s2_req2", {31'b0, intReq}, 32'd1);
        doAck();
        checkOutput("s2_vec2", {29'b0, intVec}, 32'd5);
        step();
        doReti(1'b1);
        checkOutput("s2_retie_restore", {31'b0, flgRstLd}, 32'd1);
        step();
        checkOutput("s2_retie_iflag", {31'b0, iFlag}, 32'd1);

        // Request withdrawn by CLI, then CLI together with ack
        doReset();
        doSei();
        irq = 8'h10;
        step();
        step();
        checkOutput("s4_req", {31'b0, intReq}, 32'd1);
        iClr = 1'b1;
        step();
        iClr = 1'b0;
        checkOutput("s4_withdraw", {31'b0, intReq}, 32'd0);
        checkOutput("s4_idle", {31'b0, inIsr}, 32'd0);
        doSei();
        checkOutput("s4_req_wait", {31'b0, intReq}, 32'd0);
        step();
        checkOutput("s4_req_again", {31'b0, intReq}, 32'd1);
        iClr   = 1'b1;
        intAck = 1'b1;
        step();
        iClr   = 1'b0;
        intAck = 1'b0;
        checkOutput("s4_ack_wins", {31'b0, flgShadLd}, 32'd1);
        checkOutput("s4_vec", {29'b0, intVec}, 32'd4);

        // Masked source, stray RETI and ignored ack in IDLE, then unmask
        doReset();
        doSei();
        irqMask = 8'hFB;
        irq     = 8'h04;
        step();
        step();
        step();
        checkOutput("s5_masked", {31'b0, intReq}, 32'd0);
        retiExec = 1'b1;
        retiIe   = 1'b0;
        step();
        retiExec = 1'b0;
        checkOutput("s5_stray", {31'b0, strayReti}, 32'd1);
        checkOutput("s5_stray_ldsel", {31'b0, flgLdSel}, 32'd0);
        checkOutput("s5_stray_iflag", {31'b0, iFlag}, 32'd1);
        intAck = 1'b1;
        step();
        intAck = 1'b0;
        checkOutput("s5_stray_end", {31'b0, strayReti}, 32'd0);
        checkOutput("s5_ack_ignored", {31'b0, inIsr}, 32'd0);
        irqMask = 8'hFF;
        step();
        checkOutput("s5_unmask_req", {31'b0, intReq}, 32'd1);
        doAck();
        checkOutput("s5_vec", {29'b0, intVec}, 32'd2);

        // Asynchronous reset mid-ISR with the source held high across release
        doReset();
        doSei();
        irq = 8'h08;
        step();
        step();
        doAck();
        step();
        checkOutput("s6_in_isr", {31'b0, inIsr}, 32'd1);
        rstN = 1'b0;
        #2;
        checkOutput("s6_async_isr", {31'b0, inIsr}, 32'd0);
        checkOutput("s6_async_vec", {29'b0, intVec}, 32'd0);
        checkOutput("s6_async_iflag", {31'b0, iFlag}, 32'd0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        step();
        checkOutput("s6_no_req", {31'b0, intReq}, 32'd0);
        doSei();
        step();
        checkOutput("s6_req_after_sei", {31'b0, intReq}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
